// File: rtl/cmd_frame_crc7.sv
// cmd_frame_crc7: SD host command framing stage.
// Latches a 40-bit command, runs a bit-serial CRC7 over it (MSB first) and
// presents {cmd, crc7, 1'b1} to the physical layer with a strobe/ack handshake.
// Optional macro CMD_RESP_CRC_CHECK_EN adds an independent CRC7 checker for
// 48-bit responses (ports resp_valid, resp_in, crc_ok).
module cmd_frame_crc7 #(
    parameter int unsigned PAYLOAD_W = 40,
    parameter logic [6:0]  CRC_POLY  = 7'h09
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   strobe_in,
    input  logic [PAYLOAD_W-1:0]   cmd_in,
    output logic                   ack_out,
    output logic                   strobe_out,
    input  logic                   ack_in,
    output logic [PAYLOAD_W+7:0]   frame_out,
    output logic                   busy
`ifdef CMD_RESP_CRC_CHECK_EN
    ,
    input  logic                   resp_valid,
    input  logic [PAYLOAD_W+7:0]   resp_in,
    output logic                   crc_ok
`endif
);

    localparam int unsigned CNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StHold
    } state_e;

    state_e                 state;
    logic [PAYLOAD_W-1:0]   payload;
    logic [6:0]             crc;
    logic [CNT_W-1:0]       counter;
    logic                   fb;
    logic [6:0]             crc_next;

    // One CRC7 step over the payload bit selected by the down-counter
    always_comb begin
        fb       = payload[counter] ^ crc[6];
        crc_next = {crc[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
    end

    // Framing FSM with registered handshake outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= StIdle;
            payload    <= '0;
            crc        <= '0;
            counter    <= '0;
            ack_out    <= 1'b0;
            strobe_out <= 1'b0;
            busy       <= 1'b0;
            frame_out  <= '0;
        end else begin
            ack_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (strobe_in) begin
                        payload <= cmd_in;
                        crc     <= '0;
                        counter <= CNT_LAST;
                        ack_out <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StCalc;
                    end
                end
                StCalc: begin
                    crc     <= crc_next;
                    counter <= counter - CNT_W'(1);
                    if (counter == '0) begin
                        // Last bit: frame is built from the final CRC directly
                        frame_out  <= {payload, crc_next, 1'b1};
                        strobe_out <= 1'b1;
                        state      <= StHold;
                    end
                end
                StHold: begin
                    // frame_out intentionally keeps its value after the ack
                    if (ack_in) begin
                        strobe_out <= 1'b0;
                        busy       <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef CMD_RESP_CRC_CHECK_EN
    logic                   resp_active;
    logic [PAYLOAD_W-1:0]   resp_pay;
    logic [6:0]             resp_crc_rx;
    logic                   resp_end;
    logic [6:0]             resp_crc;
    logic [CNT_W-1:0]       resp_cnt;
    logic                   resp_fb;
    logic [6:0]             resp_crc_next;

    // Response CRC step, independent of the command engine
    always_comb begin
        resp_fb       = resp_pay[resp_cnt] ^ resp_crc[6];
        resp_crc_next = {resp_crc[5:0], 1'b0} ^ (resp_fb ? CRC_POLY : 7'h00);
    end

    // Response checker: capture, serial CRC, then one-cycle crc_ok on match
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_active <= 1'b0;
            resp_pay    <= '0;
            resp_crc_rx <= '0;
            resp_end    <= 1'b0;
            resp_crc    <= '0;
            resp_cnt    <= '0;
            crc_ok      <= 1'b0;
        end else begin
            crc_ok <= 1'b0;
            if (!resp_active) begin
                if (resp_valid) begin
                    resp_pay    <= resp_in[PAYLOAD_W+7:8];
                    resp_crc_rx <= resp_in[7:1];
                    resp_end    <= resp_in[0];
                    resp_crc    <= '0;
                    resp_cnt    <= CNT_LAST;
                    resp_active <= 1'b1;
                end
            end else begin
                resp_crc <= resp_crc_next;
                resp_cnt <= resp_cnt - CNT_W'(1);
                if (resp_cnt == '0) begin
                    resp_active <= 1'b0;
                    crc_ok      <= (resp_crc_next == resp_crc_rx) && resp_end;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_frame_crc7.sv
// Testbench for cmd_frame_crc7: directed steps, expected frames queued at
// stimulus time and compared when strobe_out rises.
module tb_cmd_frame_crc7;

    logic        clock;
    logic        reset;
    logic        strobe_in;
    logic [39:0] cmd_in;
    logic        ack_out;
    logic        strobe_out;
    logic        ack_in;
    logic [47:0] frame_out;
    logic        busy;
`ifdef CMD_RESP_CRC_CHECK_EN
    logic        resp_valid;
    logic [47:0] resp_in;
    logic        crc_ok;
`endif

    cmd_frame_crc7 dut (
        .clock      (clock),
        .reset      (reset),
        .strobe_in  (strobe_in),
        .cmd_in     (cmd_in),
        .ack_out    (ack_out),
        .strobe_out (strobe_out),
        .ack_in     (ack_in),
        .frame_out  (frame_out),
        .busy       (busy)
`ifdef CMD_RESP_CRC_CHECK_EN
        ,
        .resp_valid (resp_valid),
        .resp_in    (resp_in),
        .crc_ok     (crc_ok)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          t0      = 0;
    logic [47:0] exp_q[$];

    // Reference CRC7 (x^7 + x^3 + 1), MSB first
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [6:0] c;
        logic       f;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            f = d[i] ^ c[6];
            c = {c[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Present a command and step the capture edge
    task automatic capture(input logic [39:0] cmd, input bit keep_strobe);
        strobe_in = 1'b1;
        cmd_in    = cmd;
        tick();
        t0 = cyc;
        if (!keep_strobe) strobe_in = 1'b0;
        check("ack_on_capture", {63'd0, ack_out}, 64'd1);
        check("busy_on_capture", {63'd0, busy}, 64'd1);
    endtask

    // Wait for strobe_out, optionally pulsing a stray strobe_in mid-CALC
    task automatic wait_hold(input int inject_at, input logic [39:0] inj_cmd);
        int          acks;
        logic [47:0] e;
        acks = 0;
        while (!strobe_out && (cyc - t0) < 100) begin
            if (inject_at != 0) begin
                if ((cyc - t0) == inject_at) begin
                    strobe_in = 1'b1;
                    cmd_in    = inj_cmd;
                end else begin
                    strobe_in = 1'b0;
                end
            end
            tick();
            if (ack_out) acks++;
        end
        if (inject_at != 0) strobe_in = 1'b0;
        check("hold_reached", {63'd0, strobe_out}, 64'd1);
        check("latency", 64'(cyc - t0), 64'd40);
        check("no_ack_in_calc", 64'(acks), 64'd0);
        check("busy_in_hold", {63'd0, busy}, 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 48'hxxxx_xxxx_xxxx;
        check("frame", {16'd0, frame_out}, {16'd0, e});
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("strobe_after_ack", {63'd0, strobe_out}, 64'd0);
        check("busy_after_ack", {63'd0, busy}, 64'd0);
    endtask

    localparam logic [39:0] CMD0  = 40'h40_0000_0000;
    localparam logic [39:0] CMD8  = 40'h48_0000_01AA;
    localparam logic [39:0] CMD17 = 40'h51_0000_0000;
    localparam logic [39:0] CMD55 = 40'h77_0000_0000;
    localparam logic [39:0] CMDX  = 40'h51_1234_5678;

    initial begin
        reset     = 1'b0;
        strobe_in = 1'b0;
        ack_in    = 1'b0;
        cmd_in    = '0;
`ifdef CMD_RESP_CRC_CHECK_EN
        resp_valid = 1'b0;
        resp_in    = '0;
`endif
        // Reset held three cycles
        repeat (3) tick();
        check("rst_ack", {63'd0, ack_out}, 64'd0);
        check("rst_strobe", {63'd0, strobe_out}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_frame", {16'd0, frame_out}, 64'd0);
        reset = 1'b1;
        tick();

        // CMD0
        exp_q.push_back(48'h4000_0000_0095);
        capture(CMD0, 1'b0);
        wait_hold(0, '0);
        do_ack();

        // CMD8 with a long stall before the ack
        exp_q.push_back(48'h4800_0001_AA87);
        capture(CMD8, 1'b0);
        wait_hold(0, '0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_strobe", {63'd0, strobe_out}, 64'd1);
            check("stall_frame", {16'd0, frame_out}, 64'h4800_0001_AA87);
        end
        do_ack();
        check("frame_held_after_ack", {16'd0, frame_out}, 64'h4800_0001_AA87);

        // CMD17 then CMD55 back-to-back, strobe_in held high
        exp_q.push_back(48'h5100_0000_0055);
        capture(CMD17, 1'b1);
        cmd_in = CMD55;
        wait_hold(0, '0);
        exp_q.push_back(48'h7700_0000_0065);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("b2b_strobe_low", {63'd0, strobe_out}, 64'd0);
        check("b2b_no_early_ack", {63'd0, ack_out}, 64'd0);
        check("b2b_idle", {63'd0, busy}, 64'd0);
        tick();
        t0 = cyc;
        strobe_in = 1'b0;
        check("b2b_second_ack", {63'd0, ack_out}, 64'd1);
        wait_hold(0, '0);
        do_ack();

        // Stray strobe_in with another command during CALC is ignored
        exp_q.push_back({CMDX, crc7_ref(CMDX), 1'b1});
        capture(CMDX, 1'b0);
        wait_hold(10, CMD55);
        do_ack();

        // Reset in the middle of CALC discards the command
        capture(CMD8, 1'b0);
        repeat (19) tick();
        reset = 1'b0;
        tick();
        check("midrst_ack", {63'd0, ack_out}, 64'd0);
        check("midrst_strobe", {63'd0, strobe_out}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_frame", {16'd0, frame_out}, 64'd0);
        reset = 1'b1;
        tick();
        exp_q.push_back(48'h4000_0000_0095);
        capture(CMD0, 1'b0);
        wait_hold(0, '0);
        do_ack();

`ifdef CMD_RESP_CRC_CHECK_EN
        // Good and corrupted responses through the checker
        for (int k = 0; k < 2; k++) begin
            int pulses;
            int first;
            pulses = 0;
            first  = -1;
            resp_valid = 1'b1;
            resp_in    = (k == 0) ? 48'h4000_0000_0095 : 48'h4000_0000_0097;
            tick();
            t0 = cyc;
            resp_valid = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (crc_ok) begin
                    pulses++;
                    if (first < 0) first = cyc - t0;
                end
            end
            if (k == 0) begin
                check("resp_ok_pulses", 64'(pulses), 64'd1);
                check("resp_ok_latency", 64'(first), 64'd40);
            end else begin
                check("resp_bad_pulses", 64'(pulses), 64'd0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_frame_crc7.md
Name: cmd_frame_crc7

Overview:
- Host-side CMD framing stage between cmd_controller (upstream) and cmd_phys (downstream).
- Accepts a 40-bit command (start bit, transmission bit, 6-bit index, 32-bit argument).
- Computes CRC7 bit-serially and presents the full 48-bit SD command frame {cmd, crc7, end bit} to the physical layer through a strobe/ack handshake.

Parameters:
- PAYLOAD_W, 40: payload bits covered by the CRC, processed MSB first.
- CRC_POLY, 7'h09: CRC7 polynomial x^7+x^3+1, leading x^7 term omitted.

Ports:
- clock  input  1: single clock, all logic on rising edge.
- reset  input  1: synchronous, active-low reset.
- strobe_in  input  1: upstream command valid.
- cmd_in  input  40: command payload; bit 39 start (0), bit 38 direction (1), 37:32 index, 31:0 argument.
- ack_out  output  1: one-cycle pulse confirming cmd_in was captured.
- strobe_out  output  1: frame valid to cmd_phys.
- ack_in  input  1: cmd_phys has taken the frame.
- frame_out  output  48: {payload[39:0], crc[6:0], 1'b1}.
- busy  output  1: high in CALC and HOLD.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; crc=0; bit counter=0; payload register=0; ack_out=0; strobe_out=0; busy=0; frame_out=48'h0. Reset overrides everything, including mid-CALC and mid-HOLD; the in-flight command is discarded and no ack is issued.
- IDLE:
  - If strobe_in==1 at edge T: latch cmd_in, set crc=0, counter=PAYLOAD_W-1, ack_out=1 for exactly cycle T+1, go to CALC.
  - strobe_in==0: remain in IDLE.
- CALC, one payload bit per cycle:
  - b = payload[counter]; fb = b ^ crc[6].
  - crc <= {crc[5:0],1'b0} ^ (fb ? CRC_POLY : 7'h0).
  - counter decrements. When the processed bit is counter==0, go to HOLD.
  - Takes exactly PAYLOAD_W cycles.
- HOLD:
  - frame_out = {payload, crc, 1'b1}, registered on HOLD entry. strobe_out=1.
  - frame_out and strobe_out stay stable until ack_in==1 is sampled.
  - On ack_in==1: next cycle strobe_out=0, go to IDLE. frame_out holds its last value.
- Latency: strobe_in sampled at edge T gives strobe_out==1 from edge T+PAYLOAD_W+1.
- strobe_in while busy: ignored, no ack_out, no latch. Upstream must keep strobe_in high or re-issue it.
- ack_in outside HOLD: ignored.
- Simultaneous strobe_in and ack_in in HOLD: the ack completes and returns to IDLE. The new strobe_in is not captured that cycle; it is accepted on the first IDLE cycle, so the back-to-back gap is 1 cycle.
- cmd_in bits 39/38 are passed through as given. No correction is applied.

Optional Feature:
- Macro: CMD_RESP_CRC_CHECK_EN.
- With the macro defined, the block adds three ports:
  - resp_valid (input, 1), resp_in (input, 48), crc_ok (output, 1).
  - A second independent serial CRC7 engine runs over resp_in[47:8], captured when resp_valid==1 in any state. It takes 40 cycles.
  - It then compares against resp_in[7:1] and checks resp_in[0]==1.
  - crc_ok is a registered pulse for 1 cycle on match. An error pulse is not provided; absence of crc_ok means failure.
  - resp_valid during a check in progress is ignored. crc_ok resets to 0.
- Without the macro, these ports and logic are absent. The block behaves identically otherwise.

Test Plan:
- Reset held low 3 cycles, then strobe_in=1 with cmd_in=40'h4000000000 (CMD0) -> ack_out pulses at T+1; strobe_out at T+41; frame_out=48'h400000000095.
- cmd_in=40'h48000001AA (CMD8) -> frame_out=48'h48000001AA87. Hold ack_in=0 for 20 cycles -> frame_out/strobe_out stable; ack_in=1 -> strobe_out=0 next cycle, busy=0.
- CMD17 40'h5100000000 then CMD55 40'h7700000000 back-to-back, with strobe_in held high and ack_in asserted in the first HOLD cycle -> frames 48'h510000000055 and 48'h770000000065; second ack_out one cycle after IDLE re-entry.
- strobe_in pulsed with a different cmd_in during CALC -> no ack_out; the original frame is unchanged.
- reset=0 at cycle 20 of CALC -> all outputs 0 next cycle. A new CMD0 afterwards still yields 48'h400000000095.
- CMD_RESP_CRC_CHECK_EN: resp_in=48'h400000000095 -> crc_ok pulse after 41 cycles. resp_in=48'h400000000097 -> no crc_ok.
